// File: rtl/data_memory_sync_if.sv
// ---------------------------------------------------------------------------
// data_memory_sync_if
// Request/response bundle between the MEM stage and the data RAM.
//
// Parameters:
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  byte-address width
//
// Signals:
//   ren, raddr                  read request and byte address (master -> slave)
//   wen, waddr, wstrb, wdata    write request, byte address, byte enables, data
//   rdata, rvalid               registered read data and its qualifier (slave -> master)
//   busy                        memory is running its clear sequence
//   err                         one-cycle fault pulse for an illegal access
//
// Modports:
//   master  the pipeline side that issues requests
//   slave   the memory side that answers them
// ---------------------------------------------------------------------------
interface data_memory_sync_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   localparam int BYTES = DATA_W / 8;

   logic              ren;
   logic [ADDR_W-1:0] raddr;
   logic              wen;
   logic [ADDR_W-1:0] waddr;
   logic [BYTES-1:0]  wstrb;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;
   logic              busy;
   logic              err;

   modport master (
      output ren, raddr, wen, waddr, wstrb, wdata,
      input  rdata, rvalid, busy, err
   );

   modport slave (
      input  ren, raddr, wen, waddr, wstrb, wdata,
      output rdata, rvalid, busy, err
   );
endinterface

// File: rtl/data_memory_sync.sv
// ---------------------------------------------------------------------------
// data_memory_sync
// Byte-addressed data RAM for the MEM stage with per-byte write strobes,
// registered reads (1-cycle latency, qualified by rvalid) and a hardware
// clear sequence that zeroes one word per cycle after reset.
//
// Parameters:
//   DEPTH   number of words (>= 2)
//   DATA_W  word width in bits (multiple of 8)
//   ADDR_W  byte-address width
//
// Ports:
//   clock   rising-edge clock
//   reset   synchronous, active-high; restarts the clear sequence
//   bus     data_memory_sync_if.slave: ren/raddr, wen/waddr/wstrb/wdata in,
//           rdata/rvalid/busy/err out
//
// Optional feature:
//   DMEM_BYPASS_EN  when defined, a same-cycle legal read and write to the
//                   same word returns the merged (post-write) value.
//                   When undefined the RAM is read-first.
// ---------------------------------------------------------------------------
module data_memory_sync #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   data_memory_sync_if.slave bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int OFS   = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state;
   logic [IDX_W-1:0]  ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;
   logic              busy_q;
   logic              err_q;

   // An address is illegal if it is not word aligned or if the full word
   // number (all upper bits included) is past the end of the array.
   function automatic logic illegal(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] ofs_mask;
      ofs_mask = ADDR_W'((1 << OFS) - 1);
      return ((addr & ofs_mask) != '0) || ((addr >> OFS) >= ADDR_W'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
      return IDX_W'(addr >> OFS);
   endfunction

   logic [IDX_W-1:0] ridx;
   logic [IDX_W-1:0] widx;
   logic             rd_ill;
   logic             wr_ill;
   logic             wr_ok;

   assign ridx   = word_index(bus.raddr);
   assign widx   = word_index(bus.waddr);
   assign rd_ill = illegal(bus.raddr);
   assign wr_ill = illegal(bus.waddr);
   assign wr_ok  = (state == READY) && !reset && bus.wen && !wr_ill;

   // Single write port shared by the clear sequence and user writes.
   // Clear wins, although the FSM never accepts user writes while clearing.
   // Nothing is written on an edge where reset is high.
   logic              port_en;
   logic [IDX_W-1:0]  port_idx;
   logic [BYTES-1:0]  port_be;
   logic [DATA_W-1:0] port_data;

   always_comb begin
      port_en   = 1'b0;
      port_idx  = widx;
      port_be   = bus.wstrb;
      port_data = bus.wdata;
      if (state == CLEAR) begin
         port_en   = !reset;
         port_idx  = ptr;
         port_be   = '1;
         port_data = '0;
      end else if (wr_ok) begin
         port_en = 1'b1;
      end
   end

   // Byte-granular storage update.
   always_ff @(posedge clock) begin
      if (port_en) begin
         for (int k = 0; k < BYTES; k++) begin
            if (port_be[k]) begin
               mem[port_idx][8*k +: 8] <= port_data[8*k +: 8];
            end
         end
      end
   end

   // Value captured into rdata on an accepted read. Default is read-first
   // (old contents); with forwarding enabled a same-word write is merged in.
   // Illegal reads always return zero.
   logic [DATA_W-1:0] rd_next;

   always_comb begin
      rd_next = mem[ridx];
`ifdef DMEM_BYPASS_EN
      if (wr_ok && (widx == ridx)) begin
         for (int k = 0; k < BYTES; k++) begin
            if (bus.wstrb[k]) begin
               rd_next[8*k +: 8] = bus.wdata[8*k +: 8];
            end
         end
      end
`endif
      if (rd_ill) begin
         rd_next = '0;
      end
   end

   // Control FSM: CLEAR walks ptr over every word, READY serves requests.
   // rvalid and err are single-cycle pulses; rdata holds between reads.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= CLEAR;
         ptr      <= '0;
         busy_q   <= 1'b1;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         case (state)
            CLEAR: begin
               if (ptr == IDX_W'(DEPTH - 1)) begin
                  state  <= READY;
                  ptr    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  ptr <= ptr + IDX_W'(1);
               end
            end
            READY: begin
               if (bus.ren) begin
                  rvalid_q <= 1'b1;
                  rdata_q  <= rd_next;
               end
               err_q <= (bus.ren && rd_ill) || (bus.wen && wr_ill);
            end
            default: begin
               state  <= CLEAR;
               ptr    <= '0;
               busy_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign bus.busy   = busy_q;
   assign bus.err    = err_q;
endmodule

// File: tb/tb_data_memory_sync.sv
// ---------------------------------------------------------------------------
// tb_data_memory_sync
// Scoreboard bench for data_memory_sync. Two instances are exercised: the
// default 32-bit x 64-word RAM and a 64-bit x 16-word RAM. Each request that
// should produce an output pushes its hand-computed expectation into a
// queue; a monitor process pops and compares whenever rvalid or err is seen.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_memory_sync;

   typedef struct {
      logic        rvalid;
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   logic clock = 1'b0;
   logic reset;

   int vectors     = 0;
   int miscompares = 0;

   exp_t q32[$];
   exp_t q64[$];

   always #5 clock = ~clock;

   data_memory_sync_if #(.DATA_W(32), .ADDR_W(32)) bus ();
   data_memory_sync_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

   data_memory_sync #(.DEPTH(64), .DATA_W(32), .ADDR_W(32)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   data_memory_sync #(.DEPTH(16), .DATA_W(64), .ADDR_W(32)) dut64 (
      .clock(clock),
      .reset(reset),
      .bus  (bus64)
   );

   // One comparison; every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Drive one request cycle on the 32-bit RAM and queue what should come back.
   task automatic applyStimulus(input logic ren, input logic [31:0] raddr,
                                input logic wen, input logic [31:0] waddr,
                                input logic [3:0] wstrb, input logic [31:0] wdata,
                                input logic expErr, input logic [31:0] expData);
      exp_t e;
      bus.ren   = ren;
      bus.raddr = raddr;
      bus.wen   = wen;
      bus.waddr = waddr;
      bus.wstrb = wstrb;
      bus.wdata = wdata;
      e.rvalid  = ren;
      e.rdata   = {32'd0, expData};
      e.err     = expErr;
      if (ren || expErr) q32.push_back(e);
      @(negedge clock);
      bus.ren = 1'b0;
      bus.wen = 1'b0;
   endtask

   task automatic writeWord(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic expErr);
      applyStimulus(1'b0, 32'd0, 1'b1, addr, strb, data, expErr, 32'd0);
   endtask

   task automatic readWord(input logic [31:0] addr, input logic [31:0] expData, input logic expErr);
      applyStimulus(1'b1, addr, 1'b0, 32'd0, 4'h0, 32'd0, expErr, expData);
   endtask

   task automatic applyStimulus64(input logic ren, input logic [31:0] raddr,
                                  input logic wen, input logic [31:0] waddr,
                                  input logic [7:0] wstrb, input logic [63:0] wdata,
                                  input logic expErr, input logic [63:0] expData);
      exp_t e;
      bus64.ren   = ren;
      bus64.raddr = raddr;
      bus64.wen   = wen;
      bus64.waddr = waddr;
      bus64.wstrb = wstrb;
      bus64.wdata = wdata;
      e.rvalid    = ren;
      e.rdata     = expData;
      e.err       = expErr;
      if (ren || expErr) q64.push_back(e);
      @(negedge clock);
      bus64.ren = 1'b0;
      bus64.wen = 1'b0;
   endtask

   // Count the negedges with busy high on each RAM, bounded so a stuck busy
   // still reaches the summary. Request lines are dropped the moment both
   // RAMs are ready so nothing left on the bus is accepted afterwards.
   task automatic waitClear(input int exp32, input int exp64, input string name);
      int cnt32 = 0;
      int cnt64 = 0;
      int guard = 0;
      while ((bus.busy === 1'b1 || bus64.busy === 1'b1) && guard < 300) begin
         if (bus.busy === 1'b1) cnt32++;
         if (bus64.busy === 1'b1) cnt64++;
         guard++;
         @(negedge clock);
      end
      bus.ren = 1'b0;
      bus.wen = 1'b0;
      checkOutput({name, "_busy32"}, 64'(cnt32), 64'(exp32));
      checkOutput({name, "_busy64"}, 64'(cnt64), 64'(exp64));
   endtask

   initial begin
      reset       = 1'b1;
      bus.ren     = 1'b0;
      bus.raddr   = '0;
      bus.wen     = 1'b0;
      bus.waddr   = '0;
      bus.wstrb   = '0;
      bus.wdata   = '0;
      bus64.ren   = 1'b0;
      bus64.raddr = '0;
      bus64.wen   = 1'b0;
      bus64.waddr = '0;
      bus64.wstrb = '0;
      bus64.wdata = '0;

      // Monitor: pops an expectation whenever a RAM presents rvalid or err.
      fork
         begin : monitor
            exp_t e;
            forever begin
               @(negedge clock);
               if (bus.rvalid === 1'b1 || bus.err === 1'b1) begin
                  if (q32.size() == 0) begin
                     checkOutput("unexpected32_rvalid_err", {62'd0, bus.rvalid, bus.err}, 64'd0);
                  end else begin
                     e = q32.pop_front();
                     checkOutput("flags32_rvalid_err", {62'd0, bus.rvalid, bus.err}, {62'd0, e.rvalid, e.err});
                     if (e.rvalid) checkOutput("rdata32", {32'd0, bus.rdata}, e.rdata);
                  end
               end
               if (bus64.rvalid === 1'b1 || bus64.err === 1'b1) begin
                  if (q64.size() == 0) begin
                     checkOutput("unexpected64_rvalid_err", {62'd0, bus64.rvalid, bus64.err}, 64'd0);
                  end else begin
                     e = q64.pop_front();
                     checkOutput("flags64_rvalid_err", {62'd0, bus64.rvalid, bus64.err}, {62'd0, e.rvalid, e.err});
                     if (e.rvalid) checkOutput("rdata64", bus64.rdata, e.rdata);
                  end
               end
            end
         end
      join_none

      // Reset state
      @(negedge clock);
      checkOutput("reset_rdata", {32'd0, bus.rdata}, 64'd0);
      checkOutput("reset_rvalid", {63'd0, bus.rvalid}, 64'd0);
      checkOutput("reset_err", {63'd0, bus.err}, 64'd0);
      checkOutput("reset_busy", {63'd0, bus.busy}, 64'd1);
      reset = 1'b0;
      waitClear(64, 16, "first_clear");

      // Preload all ones, then a one-cycle reset must clear every word
      for (int i = 0; i < 64; i++) writeWord(32'(i * 4), 32'hFFFF_FFFF, 4'hF, 1'b0);
      readWord(32'h1C, 32'hFFFF_FFFF, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      waitClear(64, 16, "clear_after_preload");
      for (int i = 0; i < 64; i++) readWord(32'(i * 4), 32'h0, 1'b0);

      // Byte strobes and the wstrb=0 no-op
      writeWord(32'h10, 32'h1122_3344, 4'hF, 1'b0);
      writeWord(32'h10, 32'hAABB_CCDD, 4'b0101, 1'b0);
      readWord(32'h10, 32'h11BB_33DD, 1'b0);
      writeWord(32'h10, 32'hFFFF_FFFF, 4'h0, 1'b0);
      readWord(32'h10, 32'h11BB_33DD, 1'b0);
      writeWord(32'hFC, 32'h0000_BEEF, 4'hF, 1'b0);
      readWord(32'hFC, 32'h0000_BEEF, 1'b0);

      // Faults: illegal reads return zero, illegal writes leave memory alone
      writeWord(32'h00, 32'hA5A5_A5A5, 4'hF, 1'b0);
      writeWord(32'hF0, 32'h5A5A_5A5A, 4'hF, 1'b0);
      readWord(32'h102, 32'h0, 1'b1);
      readWord(32'h11, 32'h0, 1'b1);
      readWord(32'h100, 32'h0, 1'b1);
      writeWord(32'h100, 32'h1234_5678, 4'hF, 1'b1);
      writeWord(32'hFFFF_FFF0, 32'h1234_5678, 4'hF, 1'b1);
      writeWord(32'h12, 32'h1234_5678, 4'hF, 1'b1);
      readWord(32'h00, 32'hA5A5_A5A5, 1'b0);
      readWord(32'hF0, 32'h5A5A_5A5A, 1'b0);
      readWord(32'h10, 32'h11BB_33DD, 1'b0);

      // Same-cycle collision on one word, then on different words
      writeWord(32'h20, 32'h0000_0005, 4'hF, 1'b0);
`ifdef DMEM_BYPASS_EN
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h20, 4'hF, 32'hCAFE_BABE, 1'b0, 32'hCAFE_BABE);
`else
      applyStimulus(1'b1, 32'h20, 1'b1, 32'h20, 4'hF, 32'hCAFE_BABE, 1'b0, 32'h0000_0005);
`endif
      readWord(32'h20, 32'hCAFE_BABE, 1'b0);
      applyStimulus(1'b1, 32'h10, 1'b1, 32'h24, 4'hF, 32'h0000_0077, 1'b0, 32'h11BB_33DD);
      readWord(32'h24, 32'h0000_0077, 1'b0);

      // Reset in READY drops an in-flight read; reset mid-clear restarts
      // the sequence; requests held during busy must have no effect.
      bus.ren   = 1'b1;
      bus.raddr = 32'h10;
      reset     = 1'b1;
      @(negedge clock);
      reset     = 1'b0;
      bus.ren   = 1'b1;
      bus.raddr = 32'h4;
      bus.wen   = 1'b1;
      bus.waddr = 32'h4;
      bus.wstrb = 4'hF;
      bus.wdata = 32'hDEAD_BEEF;
      repeat (30) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      waitClear(64, 16, "restart_clear");
      readWord(32'h4, 32'h0, 1'b0);
      readWord(32'h10, 32'h0, 1'b0);

      // 64-bit, 16-word instance
      applyStimulus64(1'b0, 32'h0, 1'b1, 32'h78, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0);
      applyStimulus64(1'b1, 32'h78, 1'b0, 32'h0, 8'h00, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF);
      applyStimulus64(1'b0, 32'h0, 1'b1, 32'h78, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0);
      applyStimulus64(1'b1, 32'h78, 1'b0, 32'h0, 8'h00, 64'h0, 1'b0, 64'h0123_4567_FFFF_FFFF);
      applyStimulus64(1'b1, 32'h04, 1'b0, 32'h0, 8'h00, 64'h0, 1'b1, 64'h0);
      applyStimulus64(1'b1, 32'h80, 1'b0, 32'h0, 8'h00, 64'h0, 1'b1, 64'h0);
      applyStimulus64(1'b0, 32'h0, 1'b1, 32'h80, 8'hFF, 64'h1111_2222_3333_4444, 1'b1, 64'h0);
      applyStimulus64(1'b1, 32'h00, 1'b0, 32'h0, 8'h00, 64'h0, 1'b0, 64'h0);

      // Drain: anything still queued was never answered
      repeat (3) @(negedge clock);
      checkOutput("pending32", 64'(q32.size()), 64'd0);
      checkOutput("pending64", 64'(q64.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
